// File: rtl/opera_bus_arbiter.sv
// Two-master Wishbone arbiter and address decoder for the 3DO core bus.
// Master 0 is the Zap CPU, master 1 the MADAM DMA requester.
module opera_bus_arbiter #(
  parameter int TIMEOUT      = 255,
  parameter bit DMA_PRIORITY = 1'b0
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat,
  input  logic [3:0]  m0_sel,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdat,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat,
  input  logic [3:0]  m1_sel,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdat,
  output logic [31:0] slv_adr,
  output logic [31:0] slv_wdat,
  output logic        madam_rd,
  output logic        madam_wr,
  output logic        clio_rd,
  output logic        clio_wr,
  input  logic [31:0] madam_dout,
  input  logic [31:0] clio_dout,
  output logic        ext_cyc,
  output logic        ext_stb,
  output logic        ext_we,
  output logic [31:0] ext_adr,
  output logic [31:0] ext_wdat,
  output logic [3:0]  ext_sel,
  input  logic        ext_ack,
  input  logic [31:0] ext_rdat,
  output logic [1:0]  grant
);

  typedef enum logic [2:0] {IDLE, OWN, REG, EXT, DONE} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        lastDma_q, lastDma_d;
  logic [31:0] adr_q, adr_d, wdat_q, wdat_d, rdat_q, rdat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d, err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        req0, req1, pickDma, srcDma, takeReq, ownCyc, ownStb, madamHit;
  logic [31:0] newAdr, newDat;
  logic [3:0]  newSel;
  logic        newWe;

  // XBUS holes inside the CLIO window must win over the CLIO register decode.
  function automatic logic isExt(input logic [31:0] a);
    if (a == 32'h0340_0414 || a[31:8] == 24'h03_4005) return 1'b1;
    if (a[31:16] == 16'h0330 || a[31:16] == 16'h0340) return 1'b0;
    return 1'b1;
  endfunction

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      lastDma_q <= 1'b1;
      adr_q     <= '0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      lastDma_q <= lastDma_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      rdat_q    <= rdat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    lastDma_d = lastDma_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    rdat_d    = rdat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    takeReq   = 1'b0;

    req0     = m0_cyc & m0_stb;
    req1     = m1_cyc & m1_stb;
    pickDma  = req1 & (~req0 | DMA_PRIORITY | ~lastDma_q);
    srcDma   = (state_q == IDLE) ? pickDma : grant_q[1];
    ownCyc   = grant_q[1] ? m1_cyc : m0_cyc;
    ownStb   = grant_q[1] ? m1_stb : m0_stb;
    newAdr   = srcDma ? m1_adr : m0_adr;
    newDat   = srcDma ? m1_dat : m0_dat;
    newSel   = srcDma ? m1_sel : m0_sel;
    newWe    = srcDma ? m1_we  : m0_we;
    madamHit = (adr_q[31:16] == 16'h0330);

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          takeReq   = 1'b1;
          grant_d   = pickDma ? 2'b10 : 2'b01;
          lastDma_d = pickDma;
        end
      end
      OWN: begin
        if (!ownCyc) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end else if (ownStb) begin
          takeReq = 1'b1;
        end
      end
      REG: begin
        rdat_d  = we_q ? 32'h0 : (madamHit ? madam_dout : clio_dout);
        state_d = DONE;
      end
      EXT: begin
        cnt_d = cnt_q + 8'd1;
        if (ext_ack) begin
          rdat_d  = we_q ? 32'h0 : ext_rdat;
          cnt_d   = 8'd0;
          state_d = DONE;
        end else if (cnt_q + 8'd1 == TimeoutCnt) begin
          rdat_d  = 32'h0;
          err_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = DONE;
        end
      end
      DONE: state_d = OWN;
      default: state_d = IDLE;
    endcase

    if (takeReq) begin
      adr_d   = newAdr;
      wdat_d  = newDat;
      sel_d   = newSel;
      we_d    = newWe;
      err_d   = 1'b0;
      cnt_d   = 8'd0;
      state_d = isExt(newAdr) ? EXT : REG;
    end
  end

  always_comb begin
    madam_rd = (state_q == REG) &  madamHit & ~we_q;
    madam_wr = (state_q == REG) &  madamHit &  we_q;
    clio_rd  = (state_q == REG) & ~madamHit & ~we_q;
    clio_wr  = (state_q == REG) & ~madamHit &  we_q;
    slv_adr  = adr_q;
    slv_wdat = wdat_q;
    ext_cyc  = (state_q == EXT);
    ext_stb  = (state_q == EXT);
    ext_we   = (state_q == EXT) & we_q;
    ext_adr  = adr_q;
    ext_wdat = wdat_q;
    ext_sel  = sel_q;
    m0_ack   = (state_q == DONE) & grant_q[0] & ~err_q;
    m0_err   = (state_q == DONE) & grant_q[0] &  err_q;
    m1_ack   = (state_q == DONE) & grant_q[1] & ~err_q;
    m1_err   = (state_q == DONE) & grant_q[1] &  err_q;
    m0_rdat  = ((state_q == DONE) & grant_q[0]) ? rdat_q : 32'h0;
    m1_rdat  = ((state_q == DONE) & grant_q[1]) ? rdat_q : 32'h0;
    grant    = grant_q;
  end

endmodule

// File: tb/tb_opera_bus_arbiter.sv
// Directed bench for opera_bus_arbiter: register, external, arbitration,
// back-to-back, timeout and asynchronous reset scenarios.
module tb_opera_bus_arbiter;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdat, m1_rdat;
  logic [31:0] slv_adr, slv_wdat, madam_dout, clio_dout;
  logic        madam_rd, madam_wr, clio_rd, clio_wr;
  logic        ext_cyc, ext_stb, ext_we, ext_ack;
  logic [31:0] ext_adr, ext_wdat, ext_rdat;
  logic [3:0]  ext_sel;
  logic [1:0]  grant;

  integer total = 0;
  integer bad = 0;
  int     n;

  opera_bus_arbiter #(.TIMEOUT(16), .DMA_PRIORITY(1'b0)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat(m0_dat), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_err(m0_err),
    .m0_rdat(m0_rdat),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat(m1_dat), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_err(m1_err),
    .m1_rdat(m1_rdat),
    .slv_adr(slv_adr), .slv_wdat(slv_wdat),
    .madam_rd(madam_rd), .madam_wr(madam_wr), .clio_rd(clio_rd), .clio_wr(clio_wr),
    .madam_dout(madam_dout), .clio_dout(clio_dout),
    .ext_cyc(ext_cyc), .ext_stb(ext_stb), .ext_we(ext_we), .ext_adr(ext_adr),
    .ext_wdat(ext_wdat), .ext_sel(ext_sel), .ext_ack(ext_ack), .ext_rdat(ext_rdat),
    .grant(grant)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                               input logic [31:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat = dat; m0_sel = 4'hF;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat = dat; m1_sel = 4'hF;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
    madam_dout = 32'h0; clio_dout = 32'h0; ext_ack = 1'b0; ext_rdat = 32'h0;
    #12;
    checkOutput("rst grant", grant, 2'b00);
    checkOutput("rst ext_stb", ext_stb, 1'b0);
    checkOutput("rst ext_cyc", ext_cyc, 1'b0);
    checkOutput("rst slv_adr", slv_adr, 32'h0);
    checkOutput("rst m0_ack", m0_ack, 1'b0);
    checkOutput("rst strobes", {madam_rd, madam_wr, clio_rd, clio_wr}, 4'h0);
    reset_n = 1'b1;
    tick;

    // MADAM register read: strobe at T+1, ack with data at T+2
    applyStimulus(0, 1, 1, 0, 32'h0330_0000, 32'h0);
    madam_dout = 32'h1234_5678;
    tick;
    checkOutput("t1 madam_rd", madam_rd, 1'b1);
    checkOutput("t1 grant", grant, 2'b01);
    checkOutput("t1 early ack", m0_ack, 1'b0);
    tick;
    checkOutput("t1 ack", m0_ack, 1'b1);
    checkOutput("t1 rdat", m0_rdat, 32'h1234_5678);
    checkOutput("t1 madam_rd off", madam_rd, 1'b0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    tick;
    tick;
    checkOutput("t1 grant idle", grant, 2'b00);

    // XBUS write goes external; ext_ack at T+4 gives ack at T+5
    applyStimulus(0, 1, 1, 1, 32'h0340_0414, 32'hA5A5_A5A5);
    tick;
    checkOutput("t2 ext_stb", ext_stb, 1'b1);
    checkOutput("t2 ext_we", ext_we, 1'b1);
    checkOutput("t2 ext_adr", ext_adr, 32'h0340_0414);
    checkOutput("t2 ext_wdat", ext_wdat, 32'hA5A5_A5A5);
    checkOutput("t2 ext_sel", ext_sel, 4'hF);
    checkOutput("t2 clio_wr", clio_wr, 1'b0);
    tick;
    tick;
    checkOutput("t2 ext_stb T3", ext_stb, 1'b1);
    tick;
    ext_ack = 1'b1;
    checkOutput("t2 ack T4", m0_ack, 1'b0);
    tick;
    ext_ack = 1'b0;
    checkOutput("t2 ack T5", m0_ack, 1'b1);
    checkOutput("t2 rdat", m0_rdat, 32'h0);
    checkOutput("t2 ext_stb off", ext_stb, 1'b0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    tick;
    tick;

    // Tie from reset: CPU first, then DMA on the next tie
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    applyStimulus(0, 1, 1, 0, 32'h0340_0010, 32'h0);
    applyStimulus(1, 1, 1, 0, 32'h0330_0020, 32'h0);
    clio_dout = 32'hC0C0_0001;
    madam_dout = 32'h1234_5678;
    tick;
    checkOutput("t3 grant cpu", grant, 2'b01);
    checkOutput("t3 clio_rd", clio_rd, 1'b1);
    checkOutput("t3 slv_adr", slv_adr, 32'h0340_0010);
    tick;
    checkOutput("t3 m0_ack", m0_ack, 1'b1);
    checkOutput("t3 m0_rdat", m0_rdat, 32'hC0C0_0001);
    checkOutput("t3 m1_ack idle", m1_ack, 1'b0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
    tick;
    tick;
    checkOutput("t3 grant none", grant, 2'b00);
    applyStimulus(0, 1, 1, 0, 32'h0340_0010, 32'h0);
    applyStimulus(1, 1, 1, 0, 32'h0330_0020, 32'h0);
    tick;
    checkOutput("t3 grant dma", grant, 2'b10);
    checkOutput("t3 madam_rd", madam_rd, 1'b1);
    checkOutput("t3 slv_adr dma", slv_adr, 32'h0330_0020);
    tick;
    checkOutput("t3 m1_ack", m1_ack, 1'b1);
    checkOutput("t3 m1_rdat", m1_rdat, 32'h1234_5678);
    checkOutput("t3 m0_ack idle", m0_ack, 1'b0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
    tick;
    tick;

    // CPU holds cyc for three CLIO reads while DMA waits
    applyStimulus(0, 1, 1, 0, 32'h0340_0004, 32'h0);
    applyStimulus(1, 1, 1, 0, 32'h0340_0020, 32'h0);
    clio_dout = 32'h1111_1111;
    tick;
    checkOutput("t4 grant", grant, 2'b01);
    tick;
    checkOutput("t4 ack1", m0_ack, 1'b1);
    checkOutput("t4 rdat1", m0_rdat, 32'h1111_1111);
    applyStimulus(0, 1, 1, 0, 32'h0340_0008, 32'h0);
    clio_dout = 32'h2222_2222;
    tick;
    checkOutput("t4 bubble ack", m0_ack, 1'b0);
    tick;
    checkOutput("t4 clio_rd2", clio_rd, 1'b1);
    checkOutput("t4 slv_adr2", slv_adr, 32'h0340_0008);
    tick;
    checkOutput("t4 ack2", m0_ack, 1'b1);
    checkOutput("t4 rdat2", m0_rdat, 32'h2222_2222);
    applyStimulus(0, 1, 1, 0, 32'h0340_000C, 32'h0);
    clio_dout = 32'h3333_3333;
    tick;
    tick;
    checkOutput("t4 ack3 early", m0_ack, 1'b0);
    tick;
    checkOutput("t4 ack3", m0_ack, 1'b1);
    checkOutput("t4 rdat3", m0_rdat, 32'h3333_3333);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    tick;
    checkOutput("t4 grant held", grant, 2'b01);
    checkOutput("t4 m1_ack waiting", m1_ack, 1'b0);
    tick;
    checkOutput("t4 grant released", grant, 2'b00);
    clio_dout = 32'h4444_4444;
    tick;
    checkOutput("t4 grant dma", grant, 2'b10);
    checkOutput("t4 clio_rd dma", clio_rd, 1'b1);
    tick;
    checkOutput("t4 m1_ack", m1_ack, 1'b1);
    checkOutput("t4 m1_rdat", m1_rdat, 32'h4444_4444);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
    tick;
    tick;

    // External read by DMA with no ext_ack: 16 stb cycles then err
    applyStimulus(1, 1, 1, 0, 32'h0010_0000, 32'h0);
    ext_rdat = 32'hFEED_FACE;
    tick;
    n = 0;
    while (ext_stb === 1'b1 && n < 40) begin
      n++;
      tick;
    end
    checkOutput("t5 stb cycles", n, 16);
    checkOutput("t5 m1_err", m1_err, 1'b1);
    checkOutput("t5 m1_ack", m1_ack, 1'b0);
    checkOutput("t5 m1_rdat", m1_rdat, 32'h0);
    checkOutput("t5 m0_err", m0_err, 1'b0);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
    tick;
    tick;

    // Address in the XBUS window inside CLIO space is external
    applyStimulus(0, 1, 1, 0, 32'h0340_0580, 32'h0);
    ext_rdat = 32'h0BAD_F00D;
    tick;
    checkOutput("t6 ext_stb", ext_stb, 1'b1);
    checkOutput("t6 clio_rd", clio_rd, 1'b0);
    checkOutput("t6 ext_adr", ext_adr, 32'h0340_0580);
    ext_ack = 1'b1;
    tick;
    ext_ack = 1'b0;
    checkOutput("t6 m0_ack", m0_ack, 1'b1);
    checkOutput("t6 m0_rdat", m0_rdat, 32'h0BAD_F00D);
    checkOutput("t6 ext_stb off", ext_stb, 1'b0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    tick;
    tick;

    // Asynchronous reset while waiting on the external port
    applyStimulus(0, 1, 1, 0, 32'h0020_0000, 32'h0);
    tick;
    tick;
    checkOutput("t7 ext_stb before", ext_stb, 1'b1);
    #2;
    reset_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    #1;
    checkOutput("t7 ext_stb async", ext_stb, 1'b0);
    checkOutput("t7 grant async", grant, 2'b00);
    checkOutput("t7 m0_ack async", m0_ack, 1'b0);
    #2;
    reset_n = 1'b1;
    applyStimulus(0, 1, 1, 0, 32'h0330_0100, 32'h0);
    madam_dout = 32'hDEAD_BEEF;
    tick;
    checkOutput("t7 madam_rd", madam_rd, 1'b1);
    checkOutput("t7 grant", grant, 2'b01);
    tick;
    checkOutput("t7 m0_ack", m0_ack, 1'b1);
    checkOutput("t7 m0_rdat", m0_rdat, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    tick;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opera_bus_arbiter.md
# opera_bus_arbiter

Two-master Wishbone arbiter and address decoder for the 3DO core bus. Shares one bus between the Zap CPU (master 0) and a DMA requester (master 1, MADAM engines). Decodes each access to MADAM registers, CLIO registers, or the external port (BIOS/DRAM/VRAM/NVRAM/XBUS). Generates register-slave strobes and acks, and returns read data, ack and timeout error to the owning master.

## Interface
Parameters:
- `TIMEOUT`, 255: external cycles without `ext_ack` before the error response; 8-bit counter, range 1..255.
- `DMA_PRIORITY`, 0: 1 = DMA wins every tie; 0 = round-robin on ties.

Ports:
- `sys_clk`  in  1  Single clock for the block.
- `reset_n`  in  1  Asynchronous active-low reset.
- `m0_cyc`, `m0_stb`, `m0_we`  in  1 each  CPU request.
- `m0_adr`, `m0_dat`  in  32 each  CPU address and write data.
- `m0_sel`  in  4  CPU byte lanes.
- `m0_ack`, `m0_err`  out  1 each  CPU response, one-cycle pulses.
- `m0_rdat`  out  32  CPU read data; valid while `m0_ack` is high.
- `m1_*`  same set as `m0_*`, for the DMA master.
- `slv_adr`, `slv_wdat`  out  32 each  Latched address and write data to MADAM and CLIO.
- `madam_rd`, `madam_wr`, `clio_rd`, `clio_wr`  out  1 each  One-cycle register strobes.
- `madam_dout`, `clio_dout`  in  32 each  Register read data, combinational during the strobe cycle.
- `ext_cyc`, `ext_stb`, `ext_we`  out  1 each  External port request.
- `ext_adr`, `ext_wdat`  out  32 each  External address and write data.
- `ext_sel`  out  4  External byte lanes.
- `ext_ack`  in  1  External acknowledge.
- `ext_rdat`  in  32  External read data.
- `grant`  out  2  One-hot owner: 01 = CPU, 10 = DMA, 00 = none.

## Operation
- States:
  - IDLE: no owner.
  - OWN: owner holds the bus, no access in flight.
  - REG: one-cycle register access.
  - EXT: waiting on the external port.
  - DONE: one-cycle response.
- Access decode, evaluated on the latched address in priority order:
  - XBUS: address 0x0340_0414, or 0x0340_0500..0x0340_05FF → external.
  - MADAM: 0x0330_0000..0x0330_FFFF → REG.
  - CLIO: 0x0340_0000..0x0340_FFFF → REG.
  - All other addresses → external.
- IDLE:
  - Requesters are masters with `cyc&stb` high.
  - One requester: that master is granted.
  - Two requesters: DMA wins if `DMA_PRIORITY`=1. Otherwise the master not granted last wins. The "last granted" flag resets to DMA, so the CPU wins the first tie.
  - On grant, latch adr/dat/sel/we, update `grant`, and go to REG or EXT.
- OWN:
  - Owner `cyc` low → IDLE, `grant`=00.
  - Owner `cyc&stb` high → latch the new request and go to REG or EXT. No re-arbitration while `cyc` stays high.
- REG:
  - Exactly one of the four strobes is high for this cycle, chosen by decode and `we`.
  - On reads, capture `madam_dout` or `clio_dout` into the response register.
  - → DONE.
- EXT:
  - `ext_cyc`=`ext_stb`=1, with latched adr/dat/sel/we.
  - Timeout counter increments every EXT cycle.
  - `ext_ack` seen → capture `ext_rdat`, drop `ext_cyc`/`ext_stb`, → DONE (ack).
  - Counter reaches `TIMEOUT` without ack → drop `ext_cyc`/`ext_stb`, → DONE (err).
- DONE:
  - Owner receives `ack` (with `rdat` on reads) or `err` for one cycle. On err, `rdat` = 0.
  - → OWN.
- Non-owner: its ack/err stay 0. It keeps its request pending until it is granted.
- Write responses: `rdat` = 0.
- Bytes are not merged: `sel` is forwarded to the external port only. Register writes are full 32-bit.

## Timing
- Reset (asynchronous): state IDLE, counter 0, last-granted = DMA. All outputs 0: acks, errs, rdat, strobes, `ext_*`, `slv_*`, `grant`.
- Register access: request seen in IDLE at cycle T → strobe at T+1 → ack at T+2.
- External access: request at T → `ext_stb` from T+1. `ext_ack` at cycle E → master ack at E+1.
- Timeout: `ext_stb` high for exactly `TIMEOUT` cycles → err in the next cycle.
- Back-to-back accesses by the same owner: the master presents its next request in the cycle after ack. OWN accepts it, adding one bubble cycle per access.
- `ext_ack` arriving while not in EXT is ignored.
- Owner dropping `cyc` mid-access is not aborted. The response is still issued, then OWN → IDLE.
- `reset_n` low mid-access: outputs clear immediately, with no response pulse.

## Test plan
- CPU read of 0x0330_0000 with `madam_dout`=0x1234_5678 → `madam_rd` at T+1, `m0_ack` with `m0_rdat`=0x1234_5678 at T+2, `grant`=01.
- CPU write of 0x0340_0414, data 0xA5A5_A5A5 → external path, `clio_wr` stays 0. `ext_ack` at T+4 → `m0_ack` at T+5.
- CPU and DMA request in the same cycle from reset, `DMA_PRIORITY`=0 → CPU served first. Both release and re-request together → DMA served next.
- Owner holds `cyc`, three back-to-back CLIO reads → acks at T+2, T+5, T+8. A waiting DMA is not granted until the CPU drops `cyc`.
- External read, no `ext_ack`, `TIMEOUT`=16 → `ext_stb` high 16 cycles, then `m1_err`=1, `m1_rdat`=0, `m1_ack`=0.
- `reset_n` pulsed low during EXT → `ext_stb` and `grant` go to 0 asynchronously. After release, a CPU request completes normally.
